dmem_access_ctrl: RTL and testbench



---
 rtl/dmem_access_ctrl_if.sv | 30 +++
 rtl/dmem_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// CPU request/response channel and RAM-wrapper port bundle of the data-memory access controller.
interface dmem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        addr_err;
    logic        init_done;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, addr_err, init_done,
        output mem_we, mem_addr, mem_din
    );

    // CPU plus RAM-wrapper side.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, addr_err, init_done,
        input  mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer for the 256x16 data RAM wrapper: optional zero-fill after reset,
// single outstanding request, hides the one-cycle read latency, flags out-of-range addresses.
module dmem_access_ctrl #(
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned CNT_W          = 8,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    dmem_access_ctrl_if.slave bus
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    typedef enum logic [2:0] {INIT, IDLE, ISSUE, RD_WAIT, RESP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             lat_we, lat_we_n;
    logic             lat_oor, lat_oor_n;

    logic             req_ready_q, req_ready_n;
    logic             rsp_valid_q, rsp_valid_n;
    logic [DW-1:0]    rsp_rdata_q, rsp_rdata_n;
    logic             addr_err_q, addr_err_n;
    logic             init_done_q, init_done_n;
    logic             mem_we_q, mem_we_n;
    logic [AW-1:0]    mem_addr_q, mem_addr_n;
    logic [DW-1:0]    mem_din_q, mem_din_n;

    logic             in_range;
    logic             last_clear;

    assign in_range   = 32'(bus.req_addr) < DEPTH;
    // The clear write to the top address is on the bus this cycle.
    assign last_clear = mem_we_q && (32'(mem_addr_q) == DEPTH - 32'd1);

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= INIT;
            cnt         <= '0;
            lat_we      <= 1'b0;
            lat_oor     <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_err_q  <= 1'b0;
            init_done_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            lat_we      <= lat_we_n;
            lat_oor     <= lat_oor_n;
            req_ready_q <= req_ready_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_rdata_q <= rsp_rdata_n;
            addr_err_q  <= addr_err_n;
            init_done_q <= init_done_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_din_q   <= mem_din_n;
        end
    end

    // Next state plus the output values that belong to the cycle after this edge.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        lat_we_n    = lat_we;
        lat_oor_n   = lat_oor;
        req_ready_n = req_ready_q;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata_q;
        addr_err_n  = 1'b0;
        init_done_n = init_done_q;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr_q;
        mem_din_n   = mem_din_q;

        case (state)
            INIT: begin
                if (!CLEAR_ON_RESET || last_clear) begin
                    state_n     = IDLE;
                    req_ready_n = 1'b1;
                    init_done_n = 1'b1;
                end else begin
                    mem_we_n   = 1'b1;
                    mem_addr_n = AW'(cnt);
                    mem_din_n  = '0;
                    cnt_n      = cnt + CNT_W'(1);
                end
            end
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    state_n     = ISSUE;
                    req_ready_n = 1'b0;
                    lat_we_n    = bus.req_we;
                    lat_oor_n   = !in_range;
                    mem_addr_n  = bus.req_addr;
                    addr_err_n  = !in_range;
                    if (bus.req_we && in_range) begin
                        mem_we_n  = 1'b1;
                        mem_din_n = bus.req_wdata;
                    end
                end
            end
            ISSUE: begin
                if (lat_we) begin
                    state_n     = IDLE;
                    req_ready_n = 1'b1;
                end else if (lat_oor) begin
                    // Out-of-range load answers zero without touching the RAM.
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = '0;
                end else begin
                    state_n = RD_WAIT;
                end
            end
            RD_WAIT: begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_rdata_n = bus.mem_dout;
            end
            RESP: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
            end
            default: begin
                state_n = INIT;
            end
        endcase
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.addr_err  = addr_err_q;
    assign bus.init_done = init_done_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: random and directed loads/stores against an
// array model of the RAM, with a decoupled monitor checking writes, errors and responses.
module tb_dmem_access_ctrl;
    localparam int unsigned DEPTH = 256;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic [31:0] cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] cyc = 32'd0;

    dmem_access_ctrl_if bus();

    dmem_access_ctrl #(
        .DEPTH(256),
        .CNT_W(8),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Synchronous 256x16 RAM wrapper: dout valid the cycle after the address.
    logic [15:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_addr < 16'(DEPTH)) ram[bus.mem_addr[7:0]] <= bus.mem_din;
        bus.mem_dout <= ram[bus.mem_addr[7:0]];
    end

    int          checks = 0;
    int          errors = 0;
    logic [15:0] ref_mem [DEPTH];
    ev_t         wq[$];
    ev_t         eq[$];
    ev_t         rq[$];
    bit          mon_en = 1'b0;
    logic [31:0] prev_acc = 32'd0;
    int          prev_gap = 0;

    // Reference: stores land at once, loads return current contents, out-of-range reads zero.
    task automatic model_issue(input logic we, input logic [15:0] a, input logic [15:0] d,
                               input logic [31:0] acc, output int gap);
        ev_t e;
        if (a < 16'(DEPTH)) begin
            if (we) begin
                ref_mem[a[7:0]] = d;
                e = '{a, d, acc};
                wq.push_back(e);
                gap = 2;
            end else begin
                e = '{a, ref_mem[a[7:0]], acc + 32'd2};
                rq.push_back(e);
                gap = 4;
            end
        end else begin
            e = '{a, 16'h0000, acc};
            eq.push_back(e);
            if (we) begin
                gap = 2;
            end else begin
                e = '{a, 16'h0000, acc + 32'd1};
                rq.push_back(e);
                gap = 3;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] d);
        logic [31:0] acc;
        int          g;
        acc = 32'd0;
        g   = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc = cyc + 32'd1;
                break;
            end
        end
        checks++;
        if (acc == 32'd0) begin
            errors++;
            $display("FAIL accept_timeout addr=%h: no req_ready within 20 cycles, required acceptance", a);
            prev_acc = 32'd0;
        end else begin
            if (prev_acc != 32'd0) begin
                checks++;
                if (acc - prev_acc != 32'(prev_gap)) begin
                    errors++;
                    $display("FAIL accept_gap addr=%h: got %0d cycles, required %0d", a, acc - prev_acc, prev_gap);
                end
            end
            model_issue(we, a, d, acc, g);
            prev_acc = acc;
            prev_gap = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        prev_acc = 32'd0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        logic [52:0] v;
        v = {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.addr_err, bus.init_done,
             bus.mem_we, bus.mem_addr, bus.mem_din};
        checks++;
        if (v !== 53'd0) begin
            errors++;
            $display("FAIL %s outputs=%h, required all zero", tag, v);
        end
    endtask

    // Releases reset and checks the zero-fill; optionally holds a load of 0x0005 pending throughout.
    task automatic run_init(input bit with_req);
        int          bad;
        int          bad_i;
        bit          seen;
        logic [31:0] acc;
        int          g;
        bad   = 0;
        bad_i = -1;
        seen  = 1'b0;
        bus.req_valid = with_req;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0005;
        bus.req_wdata = 16'h0000;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_we) seen = 1'b1;
            else if (bus.req_ready || bus.init_done || bus.rsp_valid) bad++;
        end
        if (!seen) bad++;
        else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (i > 0) @(negedge clk);
                if (!(bus.mem_we && bus.mem_addr == 16'(i) && bus.mem_din == 16'h0000 && !bus.req_ready
                      && !bus.init_done && !bus.rsp_valid && !bus.addr_err)) begin
                    if (bad == 0) bad_i = i;
                    bad++;
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL init_seq: %0d bad cycles (first at index %0d), required 256 zero writes 0..255 with req_ready=0", bad, bad_i);
        end
        @(negedge clk);
        checks++;
        if ({bus.init_done, bus.req_ready, bus.mem_we} !== 3'b110) begin
            errors++;
            $display("FAIL init_done {init_done,req_ready,mem_we}=%b, required 110", {bus.init_done, bus.req_ready, bus.mem_we});
        end
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 16'h0000;
        prev_acc = 32'd0;
        mon_en   = 1'b1;
        if (with_req) begin
            acc = cyc + 32'd1;
            model_issue(1'b0, 16'h0005, 16'h0000, acc, g);
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
        end
    endtask

    initial begin
        ev_t e;
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = 16'($urandom);
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 16'h0000;

        fork
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1);
            end
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    if (bus.mem_we) begin
                        checks++;
                        if (wq.size() == 0) begin
                            errors++;
                            $display("FAIL mem_write unexpected addr=%h din=%h cyc=%0d, required no write", bus.mem_addr, bus.mem_din, cyc);
                        end else begin
                            e = wq.pop_front();
                            if (bus.mem_addr !== e.addr || bus.mem_din !== e.data || cyc !== e.cyc) begin
                                errors++;
                                $display("FAIL mem_write got addr=%h din=%h cyc=%0d, required addr=%h din=%h cyc=%0d", bus.mem_addr, bus.mem_din, cyc, e.addr, e.data, e.cyc);
                            end
                        end
                    end
                    if (bus.addr_err) begin
                        checks++;
                        if (eq.size() == 0) begin
                            errors++;
                            $display("FAIL addr_err unexpected mem_addr=%h cyc=%0d, required no error", bus.mem_addr, cyc);
                        end else begin
                            e = eq.pop_front();
                            if (bus.mem_addr !== e.addr || bus.mem_we !== 1'b0 || cyc !== e.cyc) begin
                                errors++;
                                $display("FAIL addr_err got mem_addr=%h we=%b cyc=%0d, required mem_addr=%h we=0 cyc=%0d", bus.mem_addr, bus.mem_we, cyc, e.addr, e.cyc);
                            end
                        end
                    end
                    if (bus.rsp_valid) begin
                        checks++;
                        if (rq.size() == 0) begin
                            errors++;
                            $display("FAIL rsp unexpected rdata=%h cyc=%0d, required no response", bus.rsp_rdata, cyc);
                        end else begin
                            e = rq.pop_front();
                            if (bus.rsp_rdata !== e.data || cyc !== e.cyc) begin
                                errors++;
                                $display("FAIL rsp addr=%h got rdata=%h cyc=%0d, required rdata=%h cyc=%0d", e.addr, bus.rsp_rdata, cyc, e.data, e.cyc);
                            end
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset_initial");
        run_init(1'b0);
        idle(2);

        // Directed: in-range store/load, unwritten location, out-of-range store/load.
        do_req(1'b1, 16'h0012, 16'hBEEF);
        idle(1);
        do_req(1'b0, 16'h0012, 16'h0000);
        idle(3);
        do_req(1'b0, 16'h0077, 16'h0000);
        idle(3);
        do_req(1'b1, 16'h0100, 16'h1234);
        idle(2);
        do_req(1'b0, 16'h0100, 16'h0000);
        idle(3);
        do_req(1'b0, 16'hFFFF, 16'h0000);
        idle(3);

        // Back-to-back with req_valid held high.
        do_req(1'b1, 16'h0001, 16'hA5A5);
        do_req(1'b1, 16'h0002, 16'h5A5A);
        do_req(1'b0, 16'h0001, 16'h0000);
        do_req(1'b0, 16'h0002, 16'h0000);
        do_req(1'b1, 16'h00FF, 16'hC3C3);
        do_req(1'b0, 16'h00FF, 16'h0000);
        idle(4);

        // Random mixed traffic, mostly to a small window so loads hit earlier stores.
        for (int n = 0; n < 150; n++) begin
            logic        we;
            logic [15:0] a;
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) a = 16'($urandom_range(256, 65535));
            else a = 16'($urandom_range(0, 31));
            do_req(we, a, 16'($urandom));
            if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(6);

        // Reset while a load sits in its read-wait cycle; the response must be dropped.
        do_req(1'b0, 16'h0003, 16'h0000);
        @(negedge clk);
        mon_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset("reset_mid_load");
        wq.delete();
        eq.delete();
        rq.delete();
        repeat (2) @(negedge clk);
        chk_reset("reset_held");
        run_init(1'b1);
        idle(6);

        for (int n = 0; n < 30; n++) begin
            do_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom));
        end
        idle(10);

        checks++;
        if (wq.size() != 0 || eq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL pending_events writes=%0d errs=%0d rsps=%0d, required 0 0 0", wq.size(), eq.size(), rq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
